// File: rtl/stack_unit_if.sv
// rtl/stack_unit_if.sv - request/status bundle between a stack user and stack_unit
interface stack_unit_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  logic                     Push;
  logic                     Pop;
  logic [WIDTH-1:0]         DataIn;
  logic [WIDTH-1:0]         Top;
  logic                     NorTop;
  logic [$clog2(DEPTH):0]   Count;
  logic                     Empty;
  logic                     Full;
  logic                     Overflow;
  logic                     Underflow;

  modport master (
    output Push, Pop, DataIn,
    input  Top, NorTop, Count, Empty, Full, Overflow, Underflow
  );

  modport slave (
    input  Push, Pop, DataIn,
    output Top, NorTop, Count, Empty, Full, Overflow, Underflow
  );
endinterface

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - single-cycle LIFO with combinational top and sticky overflow/underflow flags
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  stack_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    sp_q, sp_d, sp_m1;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             empty, full;
  logic [WIDTH-1:0] top;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == CW'(DEPTH));
  assign sp_m1 = sp_q - CW'(1);

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    case ({bus.Push, bus.Pop})
      2'b10: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          mem_d[sp_q[AW-1:0]] = bus.DataIn;
          sp_d = sp_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty) unf_d = 1'b1;
        else       sp_d  = sp_m1;
      end
      2'b11: begin
        // Simultaneous push/pop replaces the top; on an empty stack the pop half is an underflow.
        if (empty) begin
          mem_d[0] = bus.DataIn;
          sp_d     = CW'(1);
          unf_d    = 1'b1;
        end else begin
          mem_d[sp_m1[AW-1:0]] = bus.DataIn;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign top           = empty ? '0 : mem_q[sp_m1[AW-1:0]];
  assign bus.Top       = top;
  assign bus.NorTop    = ~|top;
  assign bus.Count     = sp_q;
  assign bus.Empty     = empty;
  assign bus.Full      = full;
  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = unf_q;
endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - directed and random checks of stack_unit against a queue model
module tb_stack_unit;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [WIDTH-1:0] mdl[$];
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  stack_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_top();
    return (mdl.size() == 0) ? '0 : mdl[mdl.size()-1];
  endfunction

  // Every negedge: all outputs against the model.
  always @(negedge clk) begin
    chk("top",       32'(bus.Top),       32'(m_top()));
    chk("nortop",    32'(bus.NorTop),    32'(m_top() == '0));
    chk("count",     32'(bus.Count),     32'(mdl.size()));
    chk("empty",     32'(bus.Empty),     32'(mdl.size() == 0));
    chk("full",      32'(bus.Full),      32'(mdl.size() == DEPTH));
    chk("overflow",  32'(bus.Overflow),  32'(m_ovf));
    chk("underflow", 32'(bus.Underflow), 32'(m_unf));
  end

  task automatic model_step(input logic p, input logic q, input logic [WIDTH-1:0] d);
    if (p && q) begin
      if (mdl.size() == 0) begin
        mdl.push_back(d);
        m_unf = 1'b1;
      end else begin
        mdl[mdl.size()-1] = d;
      end
    end else if (p) begin
      if (mdl.size() == DEPTH) m_ovf = 1'b1;
      else                     mdl.push_back(d);
    end else if (q) begin
      if (mdl.size() == 0) m_unf = 1'b1;
      else                 void'(mdl.pop_back());
    end
  endtask

  // Called just after a negedge; returns just after the next negedge.
  task automatic op(input logic p, input logic q, input logic [WIDTH-1:0] d);
    bus.Push   = p;
    bus.Pop    = q;
    bus.DataIn = d;
    @(posedge clk);
    model_step(p, q, d);
    @(negedge clk);
    #1;
    bus.Push = 1'b0;
    bus.Pop  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mdl.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #2;
    rst = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.Push   = 1'b0;
    bus.Pop    = 1'b0;
    bus.DataIn = '0;
    @(negedge clk);
    #1;
    chk("rst_count",  32'(bus.Count),  32'd0);
    chk("rst_nortop", 32'(bus.NorTop), 32'd1);
    chk("rst_empty",  32'(bus.Empty),  32'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Push 0x05, 0x00, 0x3C then pop twice.
    op(1, 0, 8'h05); op(1, 0, 8'h00); op(1, 0, 8'h3C);
    chk("v1_count",  32'(bus.Count),  32'd3);
    chk("v1_top",    32'(bus.Top),    32'h3C);
    chk("v1_nortop", 32'(bus.NorTop), 32'd0);
    op(0, 1, 8'h00);
    chk("v1_top_pop1",    32'(bus.Top),    32'h00);
    chk("v1_nortop_pop1", 32'(bus.NorTop), 32'd1);
    op(0, 1, 8'h00);
    chk("v1_top_pop2", 32'(bus.Top), 32'h05);

    // Fill to capacity and push once more.
    do_reset();
    for (int i = 1; i <= 8; i++) op(1, 0, 8'(i));
    op(1, 0, 8'hFF);
    chk("v2_full",  32'(bus.Full),     32'd1);
    chk("v2_count", 32'(bus.Count),    32'd8);
    chk("v2_top",   32'(bus.Top),      32'h08);
    chk("v2_ovf",   32'(bus.Overflow), 32'd1);
    op(0, 1, 8'h00);
    chk("v2_top_pop", 32'(bus.Top),      32'h07);
    chk("v2_ovf_pop", 32'(bus.Overflow), 32'd1);

    // Pop from empty, then push.
    do_reset();
    op(0, 1, 8'h00);
    chk("v3_unf",   32'(bus.Underflow), 32'd1);
    chk("v3_count", 32'(bus.Count),     32'd0);
    chk("v3_empty", 32'(bus.Empty),     32'd1);
    chk("v3_top",   32'(bus.Top),       32'h00);
    op(1, 0, 8'h11);
    chk("v3_top_push",   32'(bus.Top),       32'h11);
    chk("v3_count_push", 32'(bus.Count),     32'd1);
    chk("v3_unf_push",   32'(bus.Underflow), 32'd1);

    // Replace top.
    do_reset();
    op(1, 0, 8'h0A); op(1, 0, 8'h0B);
    op(1, 1, 8'h22);
    chk("v4_count", 32'(bus.Count), 32'd2);
    chk("v4_top",   32'(bus.Top),   32'h22);
    op(0, 1, 8'h00);
    chk("v4_top_pop", 32'(bus.Top), 32'h0A);

    // Async reset between edges with Count=4 and Overflow set; a held push is discarded.
    do_reset();
    for (int i = 0; i < 9; i++) op(1, 0, 8'(8'h30 + i));
    for (int i = 0; i < 4; i++) op(0, 1, 8'h00);
    chk("v5_pre_count", 32'(bus.Count),    32'd4);
    chk("v5_pre_ovf",   32'(bus.Overflow), 32'd1);
    rst = 1'b1;
    mdl.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    chk("v5_count",  32'(bus.Count),    32'd0);
    chk("v5_ovf",    32'(bus.Overflow), 32'd0);
    chk("v5_nortop", 32'(bus.NorTop),   32'd1);
    bus.Push   = 1'b1;
    bus.DataIn = 8'h99;
    @(posedge clk);
    #1;
    chk("v5_push_in_reset", 32'(bus.Count), 32'd0);
    bus.Push = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Simultaneous push/pop on empty.
    op(1, 1, 8'h44);
    chk("v6_count", 32'(bus.Count),     32'd1);
    chk("v6_top",   32'(bus.Top),       32'h44);
    chk("v6_unf",   32'(bus.Underflow), 32'd1);
    chk("v6_ovf",   32'(bus.Overflow),  32'd0);

    // Random traffic, with occasional resets; push bias shifts so both ends get exercised.
    for (int n = 0; n < 1200; n++) begin
      int bias;
      bias = ((n / 150) % 2 == 0) ? 70 : 30;
      if ($urandom_range(0, 79) == 0) do_reset();
      op(logic'($urandom_range(0, 99) < bias),
         logic'($urandom_range(0, 99) < (100 - bias)),
         WIDTH'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 8: number of stack entries, a power of two and at least 2.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 Push  input  1  push request, sampled at the rising edge of clk.
REQ-006 Pop  input  1  pop request, sampled at the rising edge of clk.
REQ-007 DataIn  input  WIDTH  word written on push.
REQ-008 Top  output  WIDTH  current top-of-stack word (combinational).
REQ-009 NorTop  output  1  asserted when Top is all zeros (NOR of Top bits).
REQ-010 Count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-011 Empty  output  1  asserted when Count == 0.
REQ-012 Full  output  1  asserted when Count == DEPTH.
REQ-013 Overflow  output  1  sticky error flag: a push was attempted while the stack was full.
REQ-014 Underflow  output  1  sticky error flag: a pop was attempted while the stack was empty.

Function
REQ-015 Storage SHALL be an array mem[0..DEPTH-1] indexed by a stack pointer sp, which equals Count.
REQ-016 Top SHALL equal mem[sp-1] when not Empty, and 0 when Empty; Top has zero-cycle read latency.
- A pop and a capture of Top in the same cycle therefore return the pre-pop top.
REQ-017 NorTop SHALL equal ~|Top combinationally, so NorTop = 1 when Empty.
REQ-018 Push only, not Full: mem[sp] <= DataIn and sp <= sp+1 at the edge.
REQ-019 Pop only, not Empty: sp <= sp-1 at the edge; mem contents unchanged.
REQ-020 Push and Pop together, not Empty: the top is replaced.
- mem[sp-1] <= DataIn; sp unchanged; Overflow is not set, even when Full.
REQ-021 Push and Pop together while Empty: the pop is ignored and the push proceeds.
- Result: mem[0] <= DataIn, sp <= 1; Underflow is set.
REQ-022 Push only while Full: the push is ignored (no write, sp unchanged); Overflow <= 1.
REQ-023 Pop only while Empty: the pop is ignored (sp stays 0); Underflow <= 1.
REQ-024 Neither Push nor Pop: no state change.
REQ-025 Overflow and Underflow SHALL remain set until rst; they SHALL NOT block further legal operations.
REQ-026 sp SHALL never wrap: it stays in the range 0..DEPTH under all input sequences.
REQ-027 Push, Pop and DataIn SHALL be sampled only at the rising edge of clk; there is no handshake and no back-pressure, and every legal request completes in one cycle.
REQ-028 Empty, Full and Count SHALL be registered-derived, updating in the same edge as sp.

Reset
REQ-029 While rst is high, state SHALL be forced immediately, independent of clk:
- sp = 0 and all mem entries = 0;
- Overflow = 0, Underflow = 0;
- resulting outputs: Top = 0, NorTop = 1, Count = 0, Empty = 1, Full = 0.
REQ-030 Reset asserted mid-operation SHALL discard any request sampled in that cycle.
REQ-031 The first operation SHALL be taken on the first rising edge after rst deasserts.

Verification
REQ-032 Reset, then push 0x05, 0x00, 0x3C:
- Count = 3, Top = 0x3C, NorTop = 0;
- after one pop: Top = 0x00, NorTop = 1;
- after a second pop: Top = 0x05.
REQ-033 Push 8 values 0x01..0x08, then push 0xFF:
- Full = 1, Count = 8, Top = 0x08, Overflow = 1;
- a following pop leaves Top = 0x07, Overflow still 1.
REQ-034 From reset, pop:
- Underflow = 1, Count = 0, Empty = 1, Top = 0;
- then push 0x11: Top = 0x11, Count = 1, Underflow still 1.
REQ-035 Stack holding [0x0A, 0x0B] (0x0B on top), Push = Pop = 1 with DataIn = 0x22:
- Count = 2, Top = 0x22;
- after one pop: Top = 0x0A.
REQ-036 Stack at Count = 4 with Overflow = 1, assert rst asynchronously between clock edges:
- outputs return to reset values before the next edge: Count = 0, Overflow = 0, NorTop = 1.
REQ-037 Push = Pop = 1 with DataIn = 0x44 while Empty:
- Count = 1, Top = 0x44, Underflow = 1, Overflow = 0.
